// File: rtl/sccb_target_regif.sv
// SCCB/I2C target bridging bus transfers of {dev, addr_hi, addr_lo, data...} to a
// single-cycle register port. SCL/SDA are oversampled in the clk_24M domain.
`timescale 1ns/1ps
module sccb_target_regif #(
  parameter logic [6:0] DEV_ADDR    = 7'h3C,
  parameter int         SYNC_STAGES = 2,
  parameter int         ADDR_INC    = 1
) (
  input  logic        clk_24M,
  input  logic        camera_rstn,
  input  logic        scl,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [15:0] reg_addr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, AHI, ACK_AHI, ALO, ACK_ALO,
    WDAT, ACK_WDAT, RDAT, MACK, WAIT_P
  } state_t;

  localparam logic [15:0] INC = 16'(ADDR_INC);

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_s, sda_s, scl_d, sda_d;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]             shift;
  logic [3:0]             bit_cnt;
  logic                   rw, mack, inc_pend;
  logic [1:0]             ld_dly;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // Idle bus level is high, so synchronisers come out of reset at 1.
  always_ff @(posedge clk_24M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
    end
  end

  always_ff @(posedge clk_24M or negedge camera_rstn) begin
    if (!camera_rstn) begin
      state     <= IDLE;
      sda_oe    <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      busy      <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      rw        <= 1'b0;
      mack      <= 1'b1;
      inc_pend  <= 1'b0;
      ld_dly    <= '0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      inc_pend  <= 1'b0;
      ld_dly    <= {ld_dly[0], 1'b0};
      if (inc_pend)
        reg_addr <= reg_addr + INC;
      // Read data arrives one clk after the strobe; first bit goes out as soon as it lands.
      if (ld_dly[1]) begin
        shift  <= reg_rdata;
        sda_oe <= ~reg_rdata[7];
      end
      if (start_det) begin
        state   <= DEV;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        ld_dly  <= '0;
      end else if (stop_det) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        ld_dly  <= '0;
      end else begin
        case (state)
          DEV, AHI, ALO, WDAT: begin
            if (scl_rise) begin
              shift   <= {shift[6:0], sda_s};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (scl_fall && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              case (state)
                DEV: begin
                  if (shift[7:1] == DEV_ADDR) begin
                    rw     <= shift[0];
                    busy   <= 1'b1;
                    sda_oe <= 1'b1;
                    state  <= ACK_DEV;
                  end else begin
                    busy  <= 1'b0;
                    state <= WAIT_P;
                  end
                end
                AHI:     begin sda_oe <= 1'b1; state <= ACK_AHI;  end
                ALO:     begin sda_oe <= 1'b1; state <= ACK_ALO;  end
                default: begin sda_oe <= 1'b1; state <= ACK_WDAT; end
              endcase
            end
          end
          ACK_DEV: if (scl_fall) begin
            sda_oe  <= 1'b0;
            bit_cnt <= '0;
            if (rw) begin
              reg_rd_en <= 1'b1;
              ld_dly    <= 2'b01;
              state     <= RDAT;
            end else begin
              state <= AHI;
            end
          end
          ACK_AHI: if (scl_fall) begin
            sda_oe         <= 1'b0;
            reg_addr[15:8] <= shift;
            state          <= ALO;
          end
          ACK_ALO: if (scl_fall) begin
            sda_oe        <= 1'b0;
            reg_addr[7:0] <= shift;
            state         <= WDAT;
          end
          // Address advances the clk after the strobe so the write sees the old pointer.
          ACK_WDAT: if (scl_fall) begin
            sda_oe    <= 1'b0;
            reg_wdata <= shift;
            reg_wr_en <= 1'b1;
            inc_pend  <= 1'b1;
            state     <= WDAT;
          end
          RDAT: if (scl_fall) begin
            if (bit_cnt == 4'd7) begin
              sda_oe <= 1'b0;
              state  <= MACK;
            end else begin
              shift   <= {shift[6:0], 1'b0};
              sda_oe  <= ~shift[6];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          MACK: begin
            if (scl_rise)
              mack <= sda_s;
            else if (scl_fall) begin
              if (!mack) begin
                reg_addr  <= reg_addr + INC;
                reg_rd_en <= 1'b1;
                ld_dly    <= 2'b01;
                bit_cnt   <= '0;
                state     <= RDAT;
              end else begin
                busy  <= 1'b0;
                state <= WAIT_P;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
